// File: rtl/progrom_serial_loader_if.sv
// UART byte stream and program-ROM port bundle for progrom_serial_loader.
// master: the loader side. slave: the UART/ROM side.
interface progrom_serial_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        enprogrom;
  logic        weprogrom;
  logic [13:0] addrprogrom;
  logic [7:0]  dinprogrom;
  logic [7:0]  doutprogrom;

  modport master (
    input  rx_data, rx_valid, tx_ready, doutprogrom,
    output tx_data, tx_valid, enprogrom, weprogrom, addrprogrom, dinprogrom
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, doutprogrom,
    input  tx_data, tx_valid, enprogrom, weprogrom, addrprogrom, dinprogrom
  );
endinterface

// File: rtl/progrom_serial_loader.sv
// progrom_serial_loader: UART byte-protocol controller for the dkong program-ROM
// load/readback port. Commands: 'W' aH aL len data.. (write, returns sum + 'K'),
// 'R' aH aL len (readback), 'G' (release CPU, 'K'), 'H' (hold CPU, 'K').
// Unknown command bytes answer '?'.
// Optional macro PROGROM_LOADER_TIMEOUT_EN: an inter-byte timeout of
// TIMEOUT_CYCLES aborts a stalled header/data phase with '?'. The parameter
// only exists when the macro is defined.
module progrom_serial_loader #(
  parameter bit HOLD_AT_RESET = 1'b1
`ifdef PROGROM_LOADER_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
`endif
) (
  input  logic                           masterclk,
  input  logic                           rst_n,
  progrom_serial_loader_if.master        bus,
  output logic                           cpu_hold,
  output logic                           busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN, WDATA, WWRITE, WSUM, WACK,
    RREQ, RWAIT, RSEND, NAK
  } state_t;

  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_G = 8'h47;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_Q = 8'h3F;

  state_t      state_q, state_d;
  logic        op_rd_q, op_rd_d;
  logic [13:0] addr_q, addr_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  txd_q, txd_d;
  logic        hold_q, hold_d;
  logic        tx_vld;
  logic        tx_fire;
  logic        tmo_hit;

  assign tx_vld  = (state_q == WSUM) || (state_q == WACK) ||
                   (state_q == RSEND) || (state_q == NAK);
  assign tx_fire = tx_vld && bus.tx_ready;

`ifdef PROGROM_LOADER_TIMEOUT_EN
  logic [23:0] tmo_q, tmo_d;
  logic        waiting;

  assign waiting = (state_q == ADDR_HI) || (state_q == ADDR_LO) ||
                   (state_q == LEN) || (state_q == WDATA);
  assign tmo_hit = waiting && !bus.rx_valid && (tmo_q == TIMEOUT_CYCLES - 24'd1);
  // Idle-time counter: runs only while waiting for a header/data byte.
  assign tmo_d   = (waiting && !bus.rx_valid && !tmo_hit) ? tmo_q + 24'd1 : 24'd0;

  // Timeout counter register.
  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) tmo_q <= 24'd0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_rd_q <= 1'b0;
      addr_q  <= 14'd0;
      count_q <= 9'd0;
      sum_q   <= 8'd0;
      din_q   <= 8'd0;
      txd_q   <= 8'd0;
      hold_q  <= HOLD_AT_RESET;
    end else begin
      state_q <= state_d;
      op_rd_q <= op_rd_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      din_q   <= din_d;
      txd_q   <= txd_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state decode; bytes arriving in non-receiving states are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CH_W, CH_R: state_d = ADDR_HI;
            CH_G, CH_H: state_d = WACK;
            default:    state_d = NAK;
          endcase
        end
      ADDR_HI: if (bus.rx_valid) state_d = ADDR_LO;
      ADDR_LO: if (bus.rx_valid) state_d = LEN;
      LEN:     if (bus.rx_valid) state_d = op_rd_q ? RREQ : WDATA;
      WDATA:   if (bus.rx_valid) state_d = WWRITE;
      WWRITE:  state_d = (count_q == 9'd1) ? WSUM : WDATA;
      WSUM:    if (tx_fire) state_d = WACK;
      WACK:    if (tx_fire) state_d = IDLE;
      RREQ:    state_d = RWAIT;
      RWAIT:   state_d = RSEND;
      RSEND:   if (tx_fire) state_d = (count_q == 9'd1) ? IDLE : RREQ;
      NAK:     if (tx_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_hit) state_d = NAK;
  end

  // Datapath next values: address/count/sum bookkeeping and the tx byte.
  always_comb begin
    op_rd_d = op_rd_q;
    addr_d  = addr_q;
    count_d = count_q;
    sum_d   = sum_q;
    din_d   = din_q;
    txd_d   = txd_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE:
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CH_W:    op_rd_d = 1'b0;
            CH_R:    op_rd_d = 1'b1;
            CH_G:    begin hold_d = 1'b0; txd_d = CH_K; end
            CH_H:    begin hold_d = 1'b1; txd_d = CH_K; end
            default: txd_d = CH_Q;
          endcase
        end
      ADDR_HI: if (bus.rx_valid) addr_d[13:8] = bus.rx_data[5:0];
      ADDR_LO: if (bus.rx_valid) addr_d[7:0]  = bus.rx_data;
      LEN:
        if (bus.rx_valid) begin
          // A length byte of 0 encodes a full 256-byte block.
          count_d = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
          sum_d   = 8'd0;
        end
      WDATA:   if (bus.rx_valid) din_d = bus.rx_data;
      WWRITE: begin
        addr_d  = addr_q + 14'd1;
        sum_d   = sum_q + din_q;
        count_d = count_q - 9'd1;
        if (count_q == 9'd1) txd_d = sum_q + din_q;
      end
      WSUM:    if (tx_fire) txd_d = CH_K;
      RWAIT:   txd_d = bus.doutprogrom;
      RSEND:
        if (tx_fire) begin
          addr_d  = addr_q + 14'd1;
          count_d = count_q - 9'd1;
        end
      default: ;
    endcase
    if (tmo_hit) txd_d = CH_Q;
  end

  // Port decode straight from registered state, so reset clears strobes at once.
  always_comb begin
    bus.enprogrom   = (state_q == WWRITE) || (state_q == RREQ);
    bus.weprogrom   = (state_q == WWRITE);
    bus.addrprogrom = addr_q;
    bus.dinprogrom  = din_q;
    bus.tx_data     = txd_q;
    bus.tx_valid    = tx_vld;
    cpu_hold        = hold_q;
    busy            = (state_q != IDLE);
  end

endmodule

// File: tb/tb_progrom_serial_loader.sv
// Directed bench for progrom_serial_loader: behavioural ROM, tx/strobe monitors,
// a table of single-byte commands and hand-written multi-cycle sequences.
module tb_progrom_serial_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic cpu_hold, busy;

  always #5 clk = ~clk;

  progrom_serial_loader_if bus();

`ifdef PROGROM_LOADER_TIMEOUT_EN
  progrom_serial_loader #(.HOLD_AT_RESET(1'b1), .TIMEOUT_CYCLES(24'd100)) dut (
`else
  progrom_serial_loader #(.HOLD_AT_RESET(1'b1)) dut (
`endif
    .masterclk(clk), .rst_n(rst_n), .bus(bus.master),
    .cpu_hold(cpu_hold), .busy(busy));

  // Behavioural ROM: read data appears one cycle after a read enable.
  logic [7:0] mem [0:16383];
  always @(posedge clk) begin
    if (bus.enprogrom) begin
      if (bus.weprogrom) mem[bus.addrprogrom] <= bus.dinprogrom;
      else               bus.doutprogrom      <= mem[bus.addrprogrom];
    end
  end

  typedef struct { logic [13:0] a; logic [7:0] d; } wr_t;
  wr_t        wr_q[$];
  logic [7:0] tx_q[$];
  int         rd_cnt = 0;
  int         dbl_we = 0;
  logic       prev_we = 1'b0;

  // Monitor on the falling edge: logs transfers and ROM strobes of the coming edge.
  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    if (bus.enprogrom && bus.weprogrom) begin
      wr_q.push_back('{bus.addrprogrom, bus.dinprogrom});
      if (prev_we) dbl_we <= dbl_we + 1;
    end
    if (bus.enprogrom && !bus.weprogrom) rd_cnt <= rd_cnt + 1;
    prev_we <= bus.enprogrom && bus.weprogrom;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] txat(input int i);
    if (i < tx_q.size()) return {24'd0, tx_q[i]};
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] wra(input int i);
    if (i < wr_q.size()) return {10'd0, wr_q[i].a, wr_q[i].d};
    return 32'hDEADBEEF;
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < maxc);
    chk("wait_idle", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct { logic [7:0] rx; logic [7:0] exp_tx; logic exp_hold; } vec_t;
  vec_t tbl [6];

  initial begin
    int n, tb0, wb0, rb0, bad;
    tbl[0] = '{8'h47, 8'h4B, 1'b0};
    tbl[1] = '{8'h13, 8'h3F, 1'b0};
    tbl[2] = '{8'h48, 8'h4B, 1'b1};
    tbl[3] = '{8'h00, 8'h3F, 1'b1};
    tbl[4] = '{8'hFF, 8'h3F, 1'b1};
    tbl[5] = '{8'h47, 8'h4B, 1'b0};

    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_en",   {31'd0, bus.enprogrom}, 0);
    chk("rst_we",   {31'd0, bus.weprogrom}, 0);
    chk("rst_txv",  {31'd0, bus.tx_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_addr", {18'd0, bus.addrprogrom}, 0);
    chk("rst_din",  {24'd0, bus.dinprogrom}, 0);
    chk("rst_txd",  {24'd0, bus.tx_data}, 0);
    chk("rst_hold", {31'd0, cpu_hold}, 1);
    rst_n = 1'b1;

    // Single-byte commands from IDLE.
    for (int i = 0; i < 6; i++) begin
      tb0 = tx_q.size(); wb0 = wr_q.size(); rb0 = rd_cnt;
      send(tbl[i].rx);
      wait_idle(20, n);
      chk($sformatf("tbl%0d_ntx", i), tx_q.size() - tb0, 1);
      chk($sformatf("tbl%0d_tx", i), txat(tb0), {24'd0, tbl[i].exp_tx});
      chk($sformatf("tbl%0d_hold", i), {31'd0, cpu_hold}, {31'd0, tbl[i].exp_hold});
      chk($sformatf("tbl%0d_rom", i), (wr_q.size() - wb0) + (rd_cnt - rb0), 0);
    end

    // Write block of three bytes at 0x0100.
    tb0 = tx_q.size(); wb0 = wr_q.size(); rb0 = rd_cnt; bad = dbl_we;
    send(8'h57); send(8'h01); send(8'h00); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    wait_idle(20, n);
    chk("w_nwr",  wr_q.size() - wb0, 3);
    chk("w_wr0",  wra(wb0),     32'h0100AA);
    chk("w_wr1",  wra(wb0 + 1), 32'h0101BB);
    chk("w_wr2",  wra(wb0 + 2), 32'h0102CC);
    chk("w_1cyc", dbl_we - bad, 0);
    chk("w_nrd",  rd_cnt - rb0, 0);
    chk("w_ntx",  tx_q.size() - tb0, 2);
    chk("w_sum",  txat(tb0),     32'h31);
    chk("w_ack",  txat(tb0 + 1), 32'h4B);

    // Read the first two bytes back.
    tb0 = tx_q.size(); wb0 = wr_q.size(); rb0 = rd_cnt;
    send(8'h52); send(8'h01); send(8'h00); send(8'h02);
    wait_idle(40, n);
    chk("r_nrd", rd_cnt - rb0, 2);
    chk("r_nwr", wr_q.size() - wb0, 0);
    chk("r_ntx", tx_q.size() - tb0, 2);
    chk("r_b0",  txat(tb0),     32'hAA);
    chk("r_b1",  txat(tb0 + 1), 32'hBB);

    // Length 0 (=256) block starting at 0x3FFF wraps to 0x0000.
    tb0 = tx_q.size(); wb0 = wr_q.size();
    send(8'h57); send(8'hFF); send(8'hFF); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'h01);
    wait_idle(20, n);
    chk("wrap_nwr",  wr_q.size() - wb0, 256);
    chk("wrap_first", wra(wb0),       32'h3FFF01);
    chk("wrap_zero",  wra(wb0 + 1),   32'h000001);
    chk("wrap_last",  wra(wb0 + 255), 32'h00FE01);
    chk("wrap_ntx",  tx_q.size() - tb0, 2);
    chk("wrap_sum",  txat(tb0),     32'h00);
    chk("wrap_ack",  txat(tb0 + 1), 32'h4B);

    // One-byte read of 0x0101 with tx_ready held low.
    bus.tx_ready = 1'b0;
    tb0 = tx_q.size();
    send(8'h52); send(8'h01); send(8'h01); send(8'h01);
    n = 0;
    while (!bus.tx_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid", {31'd0, bus.tx_valid}, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.tx_valid || bus.tx_data !== 8'hBB) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_noxfer", tx_q.size() - tb0, 0);
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    wait_idle(20, n);
    chk("bp_ntx",  tx_q.size() - tb0, 1);
    chk("bp_data", txat(tb0), 32'hBB);

    // Reset asserted while the block waits for its first data byte.
    send(8'h57); send(8'h02); send(8'h00); send(8'h02);
    repeat (2) @(negedge clk);
    chk("rm_busy", {31'd0, busy}, 1);
    wb0 = wr_q.size();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_en",   {31'd0, bus.enprogrom}, 0);
    chk("rm_txv",  {31'd0, bus.tx_valid}, 0);
    chk("rm_busy0", {31'd0, busy}, 0);
    chk("rm_addr", {18'd0, bus.addrprogrom}, 0);
    chk("rm_hold", {31'd0, cpu_hold}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tb0 = tx_q.size();
    send(8'hCC);
    wait_idle(20, n);
    chk("rm_nwr", wr_q.size() - wb0, 0);
    chk("rm_nak", txat(tb0), 32'h3F);

`ifdef PROGROM_LOADER_TIMEOUT_EN
    // Header stalls after the address high byte.
    tb0 = tx_q.size();
    send(8'h57); send(8'h00);
    wait_idle(400, n);
    chk("tmo_nak",  txat(tb0), 32'h3F);
    chk("tmo_time", {31'd0, (n >= 95 && n <= 110)}, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
